texture_loader: RTL

//  SPI-slave write port that fills the wall-texture memory at run time, so texture

---
 rtl/texture_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/texture_loader.sv
// rtl/texture_loader.sv - SPI-slave write port that fills the texture RAM via single-cycle write strobes
module texture_loader #(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_csb,
    output logic                 tex_we,
    output logic [ADDR_BITS-1:0] tex_addr,
    output logic [DATA_BITS-1:0] tex_wdata,
    output logic                 load_wrap,
    output logic                 busy
);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_WRITE    = 8'h02;

    state_t     state;
    logic       sclk_s1, sclk_s2, sclk_prev;
    logic       mosi_s1, mosi_s2;
    logic       csb_s1, csb_s2;
    logic [1:0] settle;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       sclk_rise;
    logic       byte_done;
    logic [7:0] byte_next;

    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign byte_next = {shift[6:0], mosi_s2};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign busy      = (state != IDLE) && (state != WAIT_CS);

    // Two-flop synchronizers for the SPI pins plus the previous synced sclk for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            csb_s1    <= 1'b1;
            csb_s2    <= 1'b1;
        end else begin
            sclk_s1   <= spi_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            mosi_s1   <= spi_mosi;
            mosi_s2   <= mosi_s1;
            csb_s1    <= spi_csb;
            csb_s2    <= csb_s1;
        end
    end

    // The csb synchronizer resets to "deselected", so WAIT_CS must not trust csb_s2
    // until both stages have been refilled from the real pin; otherwise a reset in the
    // middle of a transaction would look like a fresh deselect and reopen the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle <= 2'd0;
        end else if (settle != 2'd2) begin
            settle <= settle + 2'd1;
        end
    end

    // Command decoder, byte assembler and write-port driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_CS;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            tex_we    <= 1'b0;
            tex_addr  <= '0;
            tex_wdata <= '0;
            load_wrap <= 1'b0;
        end else begin
            tex_we    <= 1'b0;
            load_wrap <= 1'b0;

            // The pointer advances the cycle after each write strobe
            if (tex_we) begin
                tex_addr <= tex_addr + 1'b1;
            end

            if (state == WAIT_CS) begin
                shift   <= 8'h00;
                bit_cnt <= 3'd0;
                if ((settle == 2'd2) && csb_s2) begin
                    state <= IDLE;
                end
            end else if (csb_s2) begin
                // Deselect abandons any partial byte; the pointer is kept
                state   <= IDLE;
                shift   <= 8'h00;
                bit_cnt <= 3'd0;
            end else begin
                if (state == IDLE) begin
                    state <= CMD;
                end

                if (sclk_rise) begin
                    shift   <= byte_next;
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state)
                        IDLE, CMD: begin
                            if (byte_next == CMD_SET_ADDR) begin
                                state <= ADDR_HI;
                            end else if (byte_next == CMD_WRITE) begin
                                state <= DATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR_HI: begin
                            tex_addr <= {byte_next[ADDR_BITS-9:0], tex_addr[7:0]};
                            state    <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            tex_addr <= {tex_addr[ADDR_BITS-1:8], byte_next};
                            state    <= DATA;
                        end
                        DATA: begin
                            tex_we    <= 1'b1;
                            tex_wdata <= DATA_BITS'(byte_next);
                            load_wrap <= &tex_addr;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
